// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// STATUS/CTRL bit positions and the TX/RX state encoding.
package uart_pkg;

    localparam logic [7:0] UART_DATA_OFF    = 8'h00;
    localparam logic [7:0] UART_STATUS_OFF  = 8'h04;
    localparam logic [7:0] UART_CTRL_OFF    = 8'h08;
    localparam logic [7:0] UART_DIVISOR_OFF = 8'h0C;
    localparam logic [7:0] UART_THRESH_OFF  = 8'h10;
    localparam logic [7:0] UART_COUNT_OFF   = 8'h14;

    localparam int unsigned STAT_TX_READY  = 0;
    localparam int unsigned STAT_RX_AVAIL  = 1;
    localparam int unsigned STAT_TX_IDLE   = 2;
    localparam int unsigned STAT_RX_OVF    = 3;
    localparam int unsigned STAT_FRAME_ERR = 4;

    localparam int unsigned CTRL_TX_EN      = 0;
    localparam int unsigned CTRL_RX_EN      = 1;
    localparam int unsigned CTRL_IRQ_RX_EN  = 2;
    localparam int unsigned CTRL_IRQ_TXE_EN = 3;
    localparam int unsigned CTRL_LOOPBACK   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/fifo.sv
// Synchronous show-ahead FIFO; DEPTH must be a power of two.
// Pushes while full and pops while empty are ignored.
module fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1024
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             write_enable,
    input  logic [WIDTH-1:0] write_data,
    input  logic             read_enable,
    output logic [WIDTH-1:0] read_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign read_data = mem[rd_ptr_q[AW-1:0]];

    // Storage array, written on accepted pushes.
    always_ff @(posedge clock) begin
        if (write_enable && !full) begin
            mem[wr_ptr_q[AW-1:0]] <= write_data;
        end
    end

    // Read/write pointers with wrap bit for full/empty discrimination.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (write_enable && !full) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (read_enable && !empty) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// 16x-oversampling tick generator: one-cycle tick every divisor+1 clocks.
// A new divisor takes effect at the next reload.
module uart_baud_gen (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] divisor,
    output logic        tick
);

    logic [15:0] count_q;

    assign tick = (count_q == '0);

    // Down-counter reloaded from the divisor when it reaches zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= divisor;
        end else begin
            count_q <= count_q - 16'd1;
        end
    end

endmodule

// File: rtl/mm_uart_ctrl.sv
// Memory-mapped UART with programmable divisor, 16x RX oversampling,
// TX/RX FIFOs, sticky error flags, occupancy counters and level irq.
// Optional feature macro: UART_LOOPBACK_EN (CTRL[4] internal loopback).
module mm_uart_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h90000000,
    parameter int unsigned UART_FIFO_SIZE  = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    uart_rx,
    output logic                    uart_tx,
    input  logic                    readEnable,
    input  logic                    writeEnable,
    input  logic [DATA_WIDTH/8-1:0] writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    irq
);

    localparam int unsigned CW = $clog2(UART_FIFO_SIZE) + 1;
    localparam logic [15:0] DIV_RESET = 16'(CLOCK_FREQUENCY / (16 * BAUD_RATE) - 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA   = BASE_ADDR + ADDR_WIDTH'(UART_DATA_OFF);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = BASE_ADDR + ADDR_WIDTH'(UART_STATUS_OFF);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL   = BASE_ADDR + ADDR_WIDTH'(UART_CTRL_OFF);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DIV    = BASE_ADDR + ADDR_WIDTH'(UART_DIVISOR_OFF);
    localparam logic [ADDR_WIDTH-1:0] ADDR_THRESH = BASE_ADDR + ADDR_WIDTH'(UART_THRESH_OFF);
    localparam logic [ADDR_WIDTH-1:0] ADDR_COUNT  = BASE_ADDR + ADDR_WIDTH'(UART_COUNT_OFF);

    // Configuration and status state
    logic [3:0]            ctrl_q;
    logic [15:0]           divisor_q;
    logic [CW-1:0]         rx_thresh_q;
    logic                  rx_ovf_q;
    logic                  frame_err_q;
    logic [CW-1:0]         rx_count_q;
    logic [CW-1:0]         tx_count_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic [DATA_WIDTH-1:0] wmask;
    logic [4:0]            status_vec;
    logic [4:0]            ctrl_vec;
    logic                  tick;

    // Bus decode; a simultaneous write suppresses the read
    logic wr_data, wr_status, wr_ctrl, wr_div, wr_thresh, rd_active, rx_pop;
    assign wr_data   = writeEnable & (address == ADDR_DATA) & writeByteEnable[0];
    assign wr_status = writeEnable & (address == ADDR_STATUS) & writeByteEnable[0];
    assign wr_ctrl   = writeEnable & (address == ADDR_CTRL) & writeByteEnable[0];
    assign wr_div    = writeEnable & (address == ADDR_DIV);
    assign wr_thresh = writeEnable & (address == ADDR_THRESH);
    assign rd_active = readEnable & ~writeEnable;

    // FIFOs
    logic       tx_push_ok, tx_pop, tx_empty, tx_full;
    logic       rx_push, rx_push_ok, rx_empty, rx_full;
    logic [7:0] tx_fifo_data, rx_fifo_data;

    assign tx_push_ok = wr_data & ~tx_full;
    assign rx_pop     = rd_active & (address == ADDR_DATA) & ~rx_empty;

    fifo #(.WIDTH(8), .DEPTH(UART_FIFO_SIZE)) u_tx_fifo (
        .clock(clock), .reset(reset),
        .write_enable(tx_push_ok), .write_data(writeData[7:0]),
        .read_enable(tx_pop), .read_data(tx_fifo_data),
        .empty(tx_empty), .full(tx_full)
    );

    uart_baud_gen u_baud (
        .clock(clock), .reset(reset), .divisor(divisor_q), .tick(tick)
    );

    // TX state
    uart_state_t tx_state_q, tx_state_d;
    logic [3:0]  tx_tick_q, tx_tick_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;
    logic        tx_idle;

    assign tx_idle = tx_empty & (tx_state_q == ST_IDLE);

    // RX state
    uart_state_t rx_state_q, rx_state_d;
    logic [3:0]  rx_tick_q, rx_tick_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_src, rx_s1_q, rx_s2_q, rx_prev_q;
    logic        frame_set;

    assign rx_push_ok = rx_push & ~rx_full;

    fifo #(.WIDTH(8), .DEPTH(UART_FIFO_SIZE)) u_rx_fifo (
        .clock(clock), .reset(reset),
        .write_enable(rx_push_ok), .write_data(rx_shift_q),
        .read_enable(rx_pop), .read_data(rx_fifo_data),
        .empty(rx_empty), .full(rx_full)
    );

`ifdef UART_LOOPBACK_EN
    logic loopback_q;

    // Loopback control bit.
    always_ff @(posedge clock) begin
        if (reset) loopback_q <= 1'b0;
        else if (wr_ctrl) loopback_q <= writeData[CTRL_LOOPBACK];
    end

    assign rx_src   = loopback_q ? tx_line_q : uart_rx;
    assign uart_tx  = loopback_q | tx_line_q;
    assign ctrl_vec = {loopback_q, ctrl_q};
`else
    assign rx_src   = uart_rx;
    assign uart_tx  = tx_line_q;
    assign ctrl_vec = {1'b0, ctrl_q};
`endif

    // Expand byte-lane enables to a bit mask for partial register writes.
    always_comb begin
        wmask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH / 8; i++) begin
            wmask[i*8 +: 8] = {8{writeByteEnable[i]}};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{writeData[DATA_WIDTH-1:16], wmask[DATA_WIDTH-1:16]};

    // Control, divisor and threshold registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ctrl_q      <= 4'b0011;
            divisor_q   <= DIV_RESET;
            rx_thresh_q <= CW'(1);
        end else begin
            if (wr_ctrl) ctrl_q <= writeData[3:0];
            if (wr_div) divisor_q <= (divisor_q & ~wmask[15:0]) | (writeData[15:0] & wmask[15:0]);
            if (wr_thresh) rx_thresh_q <= (rx_thresh_q & ~wmask[CW-1:0]) | (writeData[CW-1:0] & wmask[CW-1:0]);
        end
    end

    // Sticky error flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_ovf_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (rx_push & rx_full) rx_ovf_q <= 1'b1;
            else if (wr_status && writeData[STAT_RX_OVF]) rx_ovf_q <= 1'b0;
            if (frame_set) frame_err_q <= 1'b1;
            else if (wr_status && writeData[STAT_FRAME_ERR]) frame_err_q <= 1'b0;
        end
    end

    // FIFO occupancy counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            rx_count_q <= rx_count_q + CW'(rx_push_ok) - CW'(rx_pop);
            tx_count_q <= tx_count_q + CW'(tx_push_ok) - CW'(tx_pop);
        end
    end

    always_comb begin
        status_vec                 = '0;
        status_vec[STAT_TX_READY]  = ~tx_full;
        status_vec[STAT_RX_AVAIL]  = ~rx_empty;
        status_vec[STAT_TX_IDLE]   = tx_idle;
        status_vec[STAT_RX_OVF]    = rx_ovf_q;
        status_vec[STAT_FRAME_ERR] = frame_err_q;
    end

    // Read-data mux; zero whenever no read is being serviced.
    always_comb begin
        rd_d = '0;
        if (rd_active) begin
            if (address == ADDR_DATA)        rd_d = rx_empty ? '0 : DATA_WIDTH'({1'b1, rx_fifo_data});
            else if (address == ADDR_STATUS) rd_d = DATA_WIDTH'(status_vec);
            else if (address == ADDR_CTRL)   rd_d = DATA_WIDTH'(ctrl_vec);
            else if (address == ADDR_DIV)    rd_d = DATA_WIDTH'(divisor_q);
            else if (address == ADDR_THRESH) rd_d = DATA_WIDTH'(rx_thresh_q);
            else if (address == ADDR_COUNT)  rd_d = DATA_WIDTH'({16'(tx_count_q), 16'(rx_count_q)});
        end
    end

    // Registered read data and interrupt.
    always_ff @(posedge clock) begin
        if (reset) begin
            readData <= '0;
            irq      <= 1'b0;
        end else begin
            readData <= rd_d;
            irq      <= (ctrl_q[CTRL_IRQ_RX_EN] & (rx_count_q >= rx_thresh_q)) |
                        (ctrl_q[CTRL_IRQ_TXE_EN] & tx_idle);
        end
    end

    // TX state register and idle-high line register.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // TX next state; tx_en only gates the start of a new frame.
    // The line level is derived from the next state so it is registered
    // in step with the state itself.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_TX_EN] && !tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_fifo_data;
                    tx_tick_d  = '0;
                    tx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_bit_d   = '0;
                        tx_state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
                        else tx_bit_d = tx_bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                    if (tx_tick_q == 4'd15) tx_state_d = ST_IDLE;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        case (tx_state_d)
            ST_START: tx_line_d = 1'b0;
            ST_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    // RX synchroniser, edge-detect history and FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_s1_q    <= rx_src;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // RX next state. START is checked at mid-bit (8th tick) and the tick
    // counter restarts there, so every later sample lands at mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_RX_EN] && rx_prev_q && !rx_s2_q) begin
                    rx_tick_d  = '0;
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd7) begin
                        rx_tick_d = '0;
                        rx_bit_d  = '0;
                        rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
                        else rx_bit_d = rx_bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                    if (rx_tick_q == 4'd15) begin
                        rx_state_d = ST_IDLE;
                        if (rx_s2_q) rx_push = 1'b1;
                        else frame_set = 1'b1;
                    end
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mm_uart_ctrl.sv
// Self-checking bench for mm_uart_ctrl (FIFO depth 4 to reach full/overflow).
module tb_mm_uart_ctrl;

    localparam logic [31:0] BASE   = 32'h9000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h00;
    localparam logic [31:0] A_STAT = BASE + 32'h04;
    localparam logic [31:0] A_CTRL = BASE + 32'h08;
    localparam logic [31:0] A_DIV  = BASE + 32'h0C;
    localparam logic [31:0] A_THR  = BASE + 32'h10;
    localparam logic [31:0] A_CNT  = BASE + 32'h14;
`ifdef UART_LOOPBACK_EN
    localparam logic [31:0] CTRL_ALL = 32'h1F;
`else
    localparam logic [31:0] CTRL_ALL = 32'h0F;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        uart_rx = 1'b1;
    logic        uart_tx;
    logic        readEnable = 1'b0;
    logic        writeEnable = 1'b0;
    logic [3:0]  writeByteEnable = '0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        irq;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    mm_uart_ctrl #(.UART_FIFO_SIZE(4)) dut (
        .clock(clock), .reset(reset), .uart_rx(uart_rx), .uart_tx(uart_tx),
        .readEnable(readEnable), .writeEnable(writeEnable),
        .writeByteEnable(writeByteEnable), .address(address),
        .writeData(writeData), .readData(readData), .irq(irq)
    );

    initial forever #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef enum logic [1:0] {OP_RD, OP_WR, OP_RW} op_t;
    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writeData = d; writeByteEnable = be; writeEnable = 1'b1;
        step(1);
        writeEnable = 1'b0; writeByteEnable = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        address = a; readEnable = 1'b1;
        step(1);
        readEnable = 1'b0;
        d = readData;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0; step(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i]; step(16);
        end
        uart_rx = stop; step(16);
        uart_rx = 1'b1; step(4);
    endtask

    task automatic wait_tx_low(input int unsigned limit, output logic ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < limit; i++) begin
            if (uart_tx == 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        ok;
        logic [9:0]  frame;
        logic [7:0]  ovf_bytes [5];
        int unsigned t0;
        int unsigned lows;

        vq.push_back('{OP_RD, A_DIV,         32'h0,    4'hF, 32'd53});
        vq.push_back('{OP_RD, A_CTRL,        32'h0,    4'hF, 32'h3});
        vq.push_back('{OP_RD, A_STAT,        32'h0,    4'hF, 32'h5});
        vq.push_back('{OP_RD, A_THR,         32'h0,    4'hF, 32'h1});
        vq.push_back('{OP_RD, A_CNT,         32'h0,    4'hF, 32'h0});
        vq.push_back('{OP_RD, A_DATA,        32'h0,    4'hF, 32'h0});
        vq.push_back('{OP_RD, BASE + 32'h18, 32'h0,    4'hF, 32'h0});
        vq.push_back('{OP_WR, A_THR,         32'hFF,   4'hF, 32'h0});
        vq.push_back('{OP_RD, A_THR,         32'h0,    4'hF, 32'h7});
        vq.push_back('{OP_RW, A_CTRL,        32'h1F,   4'hF, 32'h0});
        vq.push_back('{OP_RD, A_CTRL,        32'h0,    4'hF, CTRL_ALL});
        vq.push_back('{OP_WR, A_CTRL,        32'h3,    4'hF, 32'h0});
        vq.push_back('{OP_WR, A_DIV,         32'h3,    4'hF, 32'h0});
        vq.push_back('{OP_RD, A_DIV,         32'h0,    4'hF, 32'h3});
        vq.push_back('{OP_WR, A_DIV,         32'hAB00, 4'h1, 32'h0});
        vq.push_back('{OP_RD, A_DIV,         32'h0,    4'hF, 32'h0});
        vq.push_back('{OP_RD, BASE + 32'h0D, 32'h0,    4'hF, 32'h0});
        vq.push_back('{OP_WR, A_STAT,        32'h18,   4'hF, 32'h0});
        vq.push_back('{OP_RD, A_STAT,        32'h0,    4'hF, 32'h5});

        step(4);
        reset = 1'b0;
        step(1);
        check("reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_readData", readData, 32'h0);

        // Register-access vectors
        foreach (vq[i]) begin
            address = vq[i].addr; writeData = vq[i].wdata; writeByteEnable = vq[i].be;
            readEnable  = (vq[i].op != OP_WR);
            writeEnable = (vq[i].op != OP_RD);
            step(1);
            readEnable = 1'b0; writeEnable = 1'b0; writeByteEnable = '0;
            check($sformatf("vec%0d", i), readData, vq[i].exp);
        end
        step(1);
        check("readData_idle_zero", readData, 32'h0);

        // Let divisor 0 take effect, then transmit 0xA5
        step(60);
        bus_write(A_DATA, 32'hA5, 4'hF);
        wait_tx_low(20, ok);
        check("tx_start_seen", {31'b0, ok}, 32'h1);
        t0 = cyc;
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 10; k++) begin
            while (cyc < t0 + 8 + 16 * k) step(1);
            check($sformatf("tx_bit%0d", k), {31'b0, uart_tx}, {31'b0, frame[k]});
        end
        read_check("tx_idle_during_stop", A_STAT, 32'h1);
        while (cyc < t0 + 170) step(1);
        read_check("tx_idle_after_stop", A_STAT, 32'h5);

        // RX two bytes with threshold interrupt
        bus_write(A_THR, 32'h2, 4'hF);
        bus_write(A_CTRL, 32'h7, 4'hF);
        send_byte(8'h3C, 1'b1);
        check("irq_below_thresh", {31'b0, irq}, 32'h0);
        send_byte(8'h7E, 1'b1);
        check("irq_at_thresh", {31'b0, irq}, 32'h1);
        read_check("rx_count2", A_CNT, 32'h2);
        read_check("rx_pop0", A_DATA, 32'h13C);
        step(2);
        check("irq_after_pop", {31'b0, irq}, 32'h0);
        read_check("rx_pop1", A_DATA, 32'h17E);
        read_check("rx_pop_empty", A_DATA, 32'h0);

        // Frame error
        send_byte(8'h55, 1'b0);
        read_check("frame_err_status", A_STAT, 32'h15);
        read_check("frame_err_count", A_CNT, 32'h0);
        bus_write(A_STAT, 32'h10, 4'hF);
        read_check("frame_err_clear", A_STAT, 32'h5);

        // RX overflow with depth 4
        ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_byte(ovf_bytes[i], 1'b1);
        read_check("ovf_count", A_CNT, 32'h4);
        read_check("ovf_status", A_STAT, 32'hF);
        for (int i = 0; i < 4; i++) begin
            read_check($sformatf("ovf_pop%0d", i), A_DATA, {23'b0, 1'b1, ovf_bytes[i]});
        end
        read_check("ovf_pop_empty", A_DATA, 32'h0);
        bus_write(A_STAT, 32'h08, 4'hF);
        read_check("ovf_clear", A_STAT, 32'h5);

        // TX full drop, then drain with tx-empty interrupt
        bus_write(A_CTRL, 32'h2, 4'hF);
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 32'h40 + i, 4'hF);
        read_check("tx_full_count", A_CNT, 32'h0004_0000);
        read_check("tx_full_status", A_STAT, 32'h0);
        bus_write(A_CTRL, 32'hA, 4'hF);
        step(2);
        check("irq_txe_busy", {31'b0, irq}, 32'h0);
        bus_write(A_CTRL, 32'hB, 4'hF);
        t0 = cyc;
        ok = 1'b0;
        while (cyc < t0 + 1000) begin
            bus_read(A_STAT, d);
            if (d[2]) begin
                ok = 1'b1;
                break;
            end
        end
        check("tx_drain_4_frames", {31'b0, (ok && (cyc - t0 >= 600) && (cyc - t0 <= 700))}, 32'h1);
        step(2);
        check("irq_txe_idle", {31'b0, irq}, 32'h1);
        read_check("tx_drained_count", A_CNT, 32'h0);

`ifdef UART_LOOPBACK_EN
        bus_write(A_CTRL, 32'h13, 4'hF);
        bus_write(A_DATA, 32'h81, 4'hF);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (uart_tx !== 1'b1) lows++;
            step(1);
        end
        check("loopback_tx_held_high", lows, 32'h0);
        read_check("loopback_rx", A_DATA, 32'h181);
`endif

        // Reset in the middle of a frame
        bus_write(A_CTRL, 32'h3, 4'hF);
        bus_write(A_DATA, 32'h00, 4'hF);
        bus_write(A_DATA, 32'h00, 4'hF);
        wait_tx_low(20, ok);
        step(20);
        check("pre_reset_tx_low", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("post_reset_uart_tx", {31'b0, uart_tx}, 32'h1);
        check("post_reset_irq", {31'b0, irq}, 32'h0);
        read_check("post_reset_count", A_CNT, 32'h0);
        read_check("post_reset_status", A_STAT, 32'h5);
        read_check("post_reset_div", A_DIV, 32'd53);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_tx !== 1'b1) lows++;
            step(1);
        end
        check("post_reset_tx_quiet", lows, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
